jac_seq_alu: RTL and testbench

Multi-cycle 8-bit ALU of the Jac1-8 core and the direct upstream producer for the status register. It accepts one operation per start pulse and returns the result together with carry/zero flags. On completion it pulses a flag-write strobe that drives the status register's write enable with the ALU source selected. Simple ops take one execute cycle; the optional multiplier iterates for 8 cycles.

---
 rtl/jac_seq_alu_if.sv | 31 +++
 rtl/jac_seq_alu.sv | 180 ++++++++++++++++++
 tb/tb_jac_seq_alu.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jac_seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : jac_seq_alu_if
// Description : Request/response bundle between the ALU and its issuer.
// Revision    : 1.0 - initial release
// ============================================================================
interface jac_seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [1:0]       alu_status;
  logic             stat_wr;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  result, result_hi, alu_status, stat_wr, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result, result_hi, alu_status, stat_wr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/jac_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : jac_seq_alu
// Description : Multi-cycle 8-bit ALU feeding the status register; the
//               shift-and-add multiplier is built only with JAC_ALU_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module jac_seq_alu (
  input  wire             clk,
  input  wire             res,
  jac_seq_alu_if.slave    bus
);
  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_SHL = 3'b101;
  localparam logic [2:0] c_OP_SHR = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_op;
  logic [7:0] r_a, r_b;
  logic [7:0] r_result, w_result_nxt;
  logic [7:0] r_result_hi, w_result_hi_nxt;
  logic [1:0] r_status, w_status_nxt;
  logic       r_done, w_done_nxt;
  logic       r_stat_wr, w_stat_wr_nxt;
  logic       w_accept;
  logic [8:0] w_sum;
  logic [7:0] w_exec_res;
  logic       w_exec_c;

`ifdef JAC_ALU_MUL_EN
  logic [15:0] r_acc, r_mcand, w_acc_nxt;
  logic [7:0]  r_mplier;
  logic [2:0]  r_cnt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : 16'h0000);

  always_ff @(posedge clk) begin
    if (res) begin
      r_acc    <= 16'h0000;
      r_mcand  <= 16'h0000;
      r_mplier <= 8'h00;
      r_cnt    <= 3'd0;
    end else if (w_accept) begin
      r_acc    <= 16'h0000;
      r_mcand  <= {8'h00, bus.a};
      r_mplier <= bus.b;
      r_cnt    <= 3'd0;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 3'd1;
    end
  end
`endif

  // Single-cycle datapath; 9-bit sum carries the add carry / subtract borrow.
  always_comb begin
    w_sum      = 9'h000;
    w_exec_res = 8'h00;
    w_exec_c   = 1'b0;
    case (r_op)
      c_OP_ADD: begin
        w_sum      = {1'b0, r_a} + {1'b0, r_b};
        w_exec_res = w_sum[7:0];
        w_exec_c   = w_sum[8];
      end
      c_OP_SUB: begin
        w_sum      = {1'b0, r_a} - {1'b0, r_b};
        w_exec_res = w_sum[7:0];
        w_exec_c   = w_sum[8];
      end
      c_OP_AND: w_exec_res = r_a & r_b;
      c_OP_OR:  w_exec_res = r_a | r_b;
      c_OP_XOR: w_exec_res = r_a ^ r_b;
      c_OP_SHL: begin
        w_exec_res = {r_a[6:0], 1'b0};
        w_exec_c   = r_a[7];
      end
      c_OP_SHR: begin
        w_exec_res = {1'b0, r_a[7:1]};
        w_exec_c   = r_a[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_result_nxt    = r_result;
    w_result_hi_nxt = r_result_hi;
    w_status_nxt    = r_status;
    w_done_nxt      = 1'b0;
    w_stat_wr_nxt   = 1'b0;
    w_accept        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
`ifdef JAC_ALU_MUL_EN
          w_state_nxt = (bus.op == c_OP_MUL) ? S_MUL : S_EXEC;
`else
          w_state_nxt = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
        // Only reachable with op 111 when the multiplier is absent: flags untouched.
        if (r_op != c_OP_MUL) begin
          w_stat_wr_nxt   = 1'b1;
          w_result_nxt    = w_exec_res;
          w_result_hi_nxt = 8'h00;
          w_status_nxt    = {(w_exec_res == 8'h00), w_exec_c};
        end
      end
      S_MUL: begin
`ifdef JAC_ALU_MUL_EN
        if (r_cnt == 3'd7) begin
          w_state_nxt     = S_IDLE;
          w_done_nxt      = 1'b1;
          w_stat_wr_nxt   = 1'b1;
          w_result_nxt    = w_acc_nxt[7:0];
          w_result_hi_nxt = w_acc_nxt[15:8];
          w_status_nxt    = {(w_acc_nxt == 16'h0000), (w_acc_nxt[15:8] != 8'h00)};
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state     <= S_IDLE;
      r_op        <= 3'b000;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_result    <= 8'h00;
      r_result_hi <= 8'h00;
      r_status    <= 2'b00;
      r_done      <= 1'b0;
      r_stat_wr   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_result    <= w_result_nxt;
      r_result_hi <= w_result_hi_nxt;
      r_status    <= w_status_nxt;
      r_done      <= w_done_nxt;
      r_stat_wr   <= w_stat_wr_nxt;
      if (w_accept) begin
        r_op <= bus.op;
        r_a  <= bus.a;
        r_b  <= bus.b;
      end
    end
  end

  assign bus.result     = r_result;
  assign bus.result_hi  = r_result_hi;
  assign bus.alu_status = r_status;
  assign bus.stat_wr    = r_stat_wr;
  assign bus.done       = r_done;
  assign bus.busy       = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_jac_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_jac_seq_alu
// Description : Self-checking bench for jac_seq_alu against an arithmetic
//               model; honours JAC_ALU_MUL_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jac_seq_alu;
  logic clk = 1'b0;
  logic res;

  jac_seq_alu_if bus ();

  jac_seq_alu dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] hi;
    logic [1:0] st;
    logic       wr;
  } pred_t;

  function automatic pred_t predict(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    pred_t p;
    int    x;
    int    ia = int'(a);
    int    ib = int'(b);
    logic  c  = 1'b0;
    p.hi = 8'h00;
    p.wr = 1'b1;
    p.r  = 8'h00;
    case (op)
      3'd0: begin x = ia + ib; p.r = 8'(x % 256); c = (x > 255); end
      3'd1: begin x = (ia - ib + 256) % 256; p.r = 8'(x); c = (ia < ib); end
      3'd2: p.r = a & b;
      3'd3: p.r = a | b;
      3'd4: p.r = a ^ b;
      3'd5: begin x = ia * 2; p.r = 8'(x % 256); c = (x > 255); end
      3'd6: begin p.r = 8'(ia / 2); c = (ia % 2 == 1); end
      default: begin
`ifdef JAC_ALU_MUL_EN
        x    = ia * ib;
        p.r  = 8'(x % 256);
        p.hi = 8'(x / 256);
        p.st = {(x == 0), (x / 256 != 0)};
        return p;
`else
        p.wr = 1'b0;
`endif
      end
    endcase
    p.st = {(p.r == 8'h00), c};
    return p;
  endfunction

  function automatic int latency(input logic [2:0] op);
`ifdef JAC_ALU_MUL_EN
    return (op == 3'd7) ? 8 : 1;
`else
    return (op == 3'd7) ? 1 : 1;
`endif
  endfunction

  // Reference model: cycles remaining until done, plus the visible outputs.
  int         m_cnt  = 0;
  logic       m_done = 1'b0;
  logic       m_stwr = 1'b0;
  logic [7:0] m_res  = 8'h00;
  logic [7:0] m_hi   = 8'h00;
  logic [1:0] m_st   = 2'b00;
  pred_t      m_pend = '0;

  always @(posedge clk) begin
    if (res) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_stwr <= 1'b0;
      m_res  <= 8'h00;
      m_hi   <= 8'h00;
      m_st   <= 2'b00;
    end else if (m_cnt > 1) begin
      m_cnt  <= m_cnt - 1;
      m_done <= 1'b0;
      m_stwr <= 1'b0;
    end else if (m_cnt == 1) begin
      m_cnt  <= 0;
      m_done <= 1'b1;
      m_stwr <= m_pend.wr;
      if (m_pend.wr) begin
        m_res <= m_pend.r;
        m_hi  <= m_pend.hi;
        m_st  <= m_pend.st;
      end
    end else begin
      m_done <= 1'b0;
      m_stwr <= 1'b0;
      if (bus.start) begin
        m_pend <= predict(bus.op, bus.a, bus.b);
        m_cnt  <= latency(bus.op);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 16'(bus.busy), 16'(m_cnt != 0));
    chk("done", 16'(bus.done), 16'(m_done));
    chk("stat_wr", 16'(bus.stat_wr), 16'(m_stwr));
    chk("result", 16'(bus.result), 16'(m_res));
    chk("result_hi", 16'(bus.result_hi), 16'(m_hi));
    chk("alu_status", 16'(bus.alu_status), 16'(m_st));
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom_range(0, 7));
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < bound);
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, bound);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] r, input logic [7:0] hi,
                         input logic [1:0] st, input logic wr);
    chk({name, "_result"}, 16'(bus.result), 16'(r));
    chk({name, "_hi"}, 16'(bus.result_hi), 16'(hi));
    chk({name, "_status"}, 16'(bus.alu_status), 16'(st));
    chk({name, "_stat_wr"}, 16'(bus.stat_wr), 16'(wr));
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    res       = 1'b1;
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 8'hFF;
    bus.b     = 8'h01;
    repeat (2) @(negedge clk);
    chk_out("reset", 8'h00, 8'h00, 2'b00, 1'b0);
    chk("reset_busy", 16'(bus.busy), 16'h0000);
    chk("reset_done", 16'(bus.done), 16'h0000);
    res       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    issue(3'd0, 8'hF0, 8'h20);
    wait_done("add", 12);
    chk_out("add", 8'h10, 8'h00, 2'b01, 1'b1);
    issue(3'd1, 8'h05, 8'h05);
    wait_done("sub_eq", 12);
    chk_out("sub_eq", 8'h00, 8'h00, 2'b10, 1'b1);
    issue(3'd1, 8'h03, 8'h05);
    wait_done("sub_borrow", 12);
    chk_out("sub_borrow", 8'hFE, 8'h00, 2'b01, 1'b1);
    // Issued in the done cycle of the previous op: must be accepted immediately.
    issue(3'd6, 8'h01, 8'h00);
    chk("b2b_busy", 16'(bus.busy), 16'h0001);
    wait_done("shr", 12);
    chk_out("shr", 8'h00, 8'h00, 2'b11, 1'b1);
    @(negedge clk);

`ifdef JAC_ALU_MUL_EN
    issue(3'd7, 8'h10, 8'h10);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("mul", 12);
    chk_out("mul", 8'h00, 8'h01, 2'b01, 1'b1);
    @(negedge clk);
    issue(3'd7, 8'h10, 8'h10);
    repeat (3) @(negedge clk);
`else
    issue(3'd7, 8'h10, 8'h10);
    chk("mul_ill_busy", 16'(bus.busy), 16'h0001);
    wait_done("mul_ill", 4);
    chk_out("mul_ill", 8'h00, 8'h00, 2'b11, 1'b0);
    @(negedge clk);
    issue(3'd0, 8'h7F, 8'h7F);
`endif
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    chk_out("abort", 8'h00, 8'h00, 2'b00, 1'b0);
    chk("abort_done", 16'(bus.done), 16'h0000);
    chk("abort_busy", 16'(bus.busy), 16'h0000);
    @(negedge clk);
    issue(3'd0, 8'h01, 8'h01);
    wait_done("add_after_abort", 12);
    chk_out("add_after_abort", 8'h02, 8'h00, 2'b00, 1'b1);

    for (int i = 0; i < 500; i++) begin
      res       = ($urandom_range(0, 79) == 0);
      bus.start = ($urandom_range(0, 2) != 0);
      bus.op    = 3'($urandom_range(0, 7));
      bus.a     = pick();
      bus.b     = pick();
      @(negedge clk);
    end
    res       = 1'b0;
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
